ternary_scoreboard: RTL and testbench
=====================================

# ternary_scoreboard

Issue-side hazard scoreboard for the ternary pipeline. It records every in-flight register write from the issue (ID) stage and holds that stage while a source or destination register's result cannot yet reach EX over the MEM/WB forwarding paths. It sits beside ID as the producer-side counterpart of the forwarding unit. The forwarding unit only routes results that already exist; this block makes sure nothing issues before they exist. Register addresses are 3 trits (6 bits), decoded with the `T_NEG`/`T_ZERO`/`T_POS` macros from `ternary_defs.vh`.

## Interface
- `NREGS`, 27: entries, one per 3-trit address.
- `LAT_W`, 3: width of latency field and per-entry countdown.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `id_valid`  in  1  instruction present in ID.
- `id_rs1`, `id_rs2`  in  6 each  source addresses; 2 bits per trit, trit0 = [1:0].
- `id_uses_rs1`, `id_uses_rs2`  in  1 each  the instruction reads that source.
- `id_rd`  in  6  destination address.
- `id_reg_write`  in  1  the instruction writes `id_rd`.
- `id_lat`  in  LAT_W  cycles until result is forwardable from MEM; ALU = 1, load = 2, multi-cycle ops up to 7. A value of 0 is treated as 1.
- `wb_valid`  in  1  writeback commit this cycle.
- `wb_rd`  in  6  committed destination.
- `flush`  in  1  pipeline flush (branch/trap).
- `stall`  out  1  combinational; hold ID/IF and insert bubble into EX.
- `busy_vec`  out  NREGS  registered; bit i = entry i has an uncommitted write.
- `illegal_addr`  out  1  registered one-cycle pulse; an active address contained trit encoding 2'b11.

## Operation
- Index mapping: balanced value v = 9·t2 + 3·t1 + t0, each t ∈ {−1, 0, +1}; index = v + 13. R0 (all `T_ZERO`) is index 13. R0 is never recorded and never stalls.
- Per-entry state:
  - `busy` (1 bit).
  - `cnt` (LAT_W bits): remaining cycles until the result is forwardable.
- Issue fires when `id_valid && !stall && !flush`. If it fires with `id_reg_write` set and `id_rd` legal and not R0:
  - `busy[rd]` ← 1.
  - `cnt[rd]` ← max(`id_lat`, 1) − 1.
- Every cycle, each entry with `cnt` > 0 and no issue load decrements by 1. `cnt` saturates at 0.
- Commit: `wb_valid` with a legal `wb_rd` clears `busy[wb_rd]` and `cnt[wb_rd]`.
- Stall condition is `id_valid && (raw1 || raw2 || waw)`:
  - raw1 = `id_uses_rs1` && rs1 legal, not R0, `busy[rs1]` && `cnt[rs1]` ≠ 0. raw2 is the same for rs2.
  - waw = `id_reg_write` && rd legal, not R0, `busy[rd]` && `cnt[rd]` ≠ 0.
  - Stall is evaluated only from the current registered state. A commit or decrement in the same cycle does not release the stall until the next cycle.
- Address with trit 2'b11:
  - Never matches and never stalls.
  - If it is an rd, it is not recorded.
  - `illegal_addr` pulses the next cycle if it appeared on an active address: a used rs with `id_valid`, an rd with `id_valid && id_reg_write`, or `wb_rd` with `wb_valid`.
- `flush` clears all `busy`/`cnt` next edge. No issue is recorded in a flush cycle, and `stall` is forced to 0 while `flush` is high.
- Simultaneous events on the same entry:
  - Issue vs commit: issue wins (entry is busy, `cnt` loaded).
  - Issue vs decrement: the load wins.
  - Flush vs anything: flush wins.

## Timing
- Reset: all `busy`/`cnt` = 0, `busy_vec` = 0, `illegal_addr` = 0. `stall` = 0 while `rst` is high and after reset until an issue is recorded.
- Producer issued at cycle N with latency L, then a dependent instruction in ID:
  - The dependent issues at cycle N+L.
  - L = 1: back-to-back, no bubble (MEM forward).
  - L = 2: one bubble.
  - L = 7: six bubbles.
- `busy_vec` reflects issue/commit one cycle after the event.
- `stall` has zero latency from the ID inputs. There is no combinational path from `wb_*` or `flush` to `stall`, except the `flush` force-to-0.
- Reset asserted mid-operation: all state is zeroed on that edge. Outstanding writes are forgotten and no pulses are produced.

## Test plan
- ALU issue rd = (0,0,+) (index 14), L = 1 at cycle 0; at cycle 1, instruction reading rs1 = index 14 → `stall` = 0 and it issues at cycle 1; `busy_vec[14]` = 1 from cycle 1 until the cycle after `wb_valid`/`wb_rd` = index 14.
- Load rd index 5, L = 2; dependent rs2 = index 5 in ID from cycle 1 → `stall` = 1 at cycle 1 only, issue at cycle 2. Repeat with L = 7 → `stall` high for cycles 1–6.
- L = 4 write to index 20 followed by another write to index 20 → `stall` (WAW) for 3 cycles. Same-cycle issue to 20 and commit of 20 → `busy_vec[20]` stays 1.
- rd = R0 (index 13) with L = 7, then a reader of R0 → never stalls, `busy_vec` = 0.
- Two pending entries, `flush` asserted at cycle k with a valid issue → `busy_vec` = 0 at k+1, the issued instruction is not recorded, and `stall` = 0 at k.
- rs1 = 6'b11_01_01 with `id_valid` and `id_uses_rs1` → `stall` = 0, `illegal_addr` = 1 for exactly one cycle. `rst` during a pending L = 7 entry → all outputs 0 next cycle.

Source files
------------

// File: rtl/ternary_scoreboard.sv
// ternary_scoreboard
//
// Issue-side hazard scoreboard for the ternary pipeline. It tracks every
// in-flight register write issued from ID. It holds ID while a source or
// destination register's result cannot yet reach EX over the MEM/WB
// forwarding paths.
//
// Register addresses are 3 trits, 2 bits per trit, with trit0 = [1:0].
// The trit encodings are T_ZERO = 2'b00, T_POS = 2'b01 and T_NEG = 2'b10.
// The encoding 2'b11 is illegal.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   id_valid           instruction present in ID
//   id_rs1/id_rs2      source addresses; id_uses_rs1/2 qualify them
//   id_rd/id_reg_write destination address and write enable
//   id_lat             cycles until the result is forwardable from MEM (0 acts as 1)
//   wb_valid/wb_rd     writeback commit
//   flush              pipeline flush; clears all entries
//   stall              combinational hold for ID/IF
//   busy_vec           registered per-entry busy flags
//   illegal_addr       registered one-cycle pulse on an active illegal address
module ternary_scoreboard #(
  parameter int unsigned NREGS = 27,
  parameter int unsigned LAT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [5:0]       id_rs1,
  input  logic [5:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [5:0]       id_rd,
  input  logic             id_reg_write,
  input  logic [LAT_W-1:0] id_lat,
  input  logic             wb_valid,
  input  logic [5:0]       wb_rd,
  input  logic             flush,
  output logic             stall,
  output logic [NREGS-1:0] busy_vec,
  output logic             illegal_addr
);

  localparam int unsigned IDX_W = $clog2(NREGS);

  localparam logic [1:0] T_ZERO = 2'b00;
  localparam logic [1:0] T_POS  = 2'b01;
  localparam logic [1:0] T_NEG  = 2'b10;
  localparam logic [5:0] R0_ADDR = {T_ZERO, T_ZERO, T_ZERO};

  // Trit value shifted by +1, so that the digit lies in 0..2.
  function automatic logic [IDX_W-1:0] trit_digit(input logic [1:0] t);
    logic [IDX_W-1:0] d;
    case (t)
      T_NEG:   d = IDX_W'(0);
      T_ZERO:  d = IDX_W'(1);
      T_POS:   d = IDX_W'(2);
      default: d = IDX_W'(0);
    endcase
    return d;
  endfunction

  // The balanced value plus 13 equals 9*d2 + 3*d1 + d0, where each digit is shifted by +1.
  function automatic logic [IDX_W-1:0] addr_idx(input logic [5:0] a);
    return IDX_W'(9) * trit_digit(a[5:4]) + IDX_W'(3) * trit_digit(a[3:2])
           + trit_digit(a[1:0]);
  endfunction

  function automatic logic addr_legal(input logic [5:0] a);
    return (a[1:0] != 2'b11) && (a[3:2] != 2'b11) && (a[5:4] != 2'b11);
  endfunction

  logic [NREGS-1:0] busy_q, busy_d;
  logic [LAT_W-1:0] cnt_q [NREGS];
  logic [LAT_W-1:0] cnt_d [NREGS];
  logic             ill_q, ill_d;

  logic [IDX_W-1:0] rs1_idx, rs2_idx, rd_idx, wb_idx;
  logic             rs1_legal, rs2_legal, rd_legal, wb_legal;
  logic             rs1_track, rs2_track, rd_track;
  logic             raw1, raw2, waw;
  logic             issue, record;
  logic [LAT_W-1:0] lat_m1;

  assign rs1_idx   = addr_idx(id_rs1);
  assign rs2_idx   = addr_idx(id_rs2);
  assign rd_idx    = addr_idx(id_rd);
  assign wb_idx    = addr_idx(wb_rd);
  assign rs1_legal = addr_legal(id_rs1);
  assign rs2_legal = addr_legal(id_rs2);
  assign rd_legal  = addr_legal(id_rd);
  assign wb_legal  = addr_legal(wb_rd);

  // R0 is never recorded, and it never causes a stall.
  assign rs1_track = rs1_legal && (id_rs1 != R0_ADDR);
  assign rs2_track = rs2_legal && (id_rs2 != R0_ADDR);
  assign rd_track  = rd_legal && (id_rd != R0_ADDR);

  // A busy entry whose countdown has reached 0 can be forwarded, so it does not hazard.
  assign raw1 = id_uses_rs1 && rs1_track && busy_q[rs1_idx] && (cnt_q[rs1_idx] != '0);
  assign raw2 = id_uses_rs2 && rs2_track && busy_q[rs2_idx] && (cnt_q[rs2_idx] != '0);
  assign waw  = id_reg_write && rd_track && busy_q[rd_idx] && (cnt_q[rd_idx] != '0);

  // The only inputs outside ID that reach stall are flush and rst, which force it to 0.
  assign stall  = id_valid && (raw1 || raw2 || waw) && !flush && !rst;
  assign issue  = id_valid && !stall && !flush;
  assign record = issue && id_reg_write && rd_track;
  assign lat_m1 = (id_lat == '0) ? '0 : id_lat - LAT_W'(1);

  assign ill_d = (id_valid && ((id_uses_rs1 && !rs1_legal) || (id_uses_rs2 && !rs2_legal) ||
                               (id_reg_write && !rd_legal))) ||
                 (wb_valid && !wb_legal);

  // Priority, from lowest to highest: decrement, commit, issue load, flush.
  always_comb begin
    busy_d = busy_q;
    for (int unsigned i = 0; i < NREGS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - LAT_W'(1);
    end
    if (wb_valid && wb_legal) begin
      busy_d[wb_idx] = 1'b0;
      cnt_d[wb_idx]  = '0;
    end
    if (record) begin
      busy_d[rd_idx] = 1'b1;
      cnt_d[rd_idx]  = lat_m1;
    end
    if (flush) begin
      busy_d = '0;
      for (int unsigned i = 0; i < NREGS; i++) cnt_d[i] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      ill_q  <= 1'b0;
      for (int unsigned i = 0; i < NREGS; i++) cnt_q[i] <= '0;
    end else begin
      busy_q <= busy_d;
      ill_q  <= ill_d;
      for (int unsigned i = 0; i < NREGS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign busy_vec     = busy_q;
  assign illegal_addr = ill_q;

endmodule

// File: tb/tb_ternary_scoreboard.sv
// Testbench for ternary_scoreboard. Per-cycle vectors are applied from a table.
// The expected outputs for each cycle go into a queue as the cycle is driven, and are
// compared at the falling edge. A hand-written sequence then measures the bubble
// count for L = 3.
module tb_ternary_scoreboard;

  localparam logic [5:0] R0  = 6'b00_00_00;  // index 13
  localparam logic [5:0] R14 = 6'b00_00_01;  // (0,0,+)
  localparam logic [5:0] R5  = 6'b10_00_01;  // (-,0,+)
  localparam logic [5:0] R20 = 6'b01_10_01;  // (+,-,+)
  localparam logic [5:0] R22 = 6'b01_00_00;  // (+,0,0)
  localparam logic [5:0] ILL = 6'b11_01_01;

  localparam logic [26:0] B5  = 27'd1 << 5;
  localparam logic [26:0] B14 = 27'd1 << 14;
  localparam logic [26:0] B20 = 27'd1 << 20;
  localparam logic [26:0] B22 = 27'd1 << 22;

  logic        clk = 1'b0;
  logic        rst, id_valid, id_uses_rs1, id_uses_rs2, id_reg_write, wb_valid, flush;
  logic [5:0]  id_rs1, id_rs2, id_rd, wb_rd;
  logic [2:0]  id_lat;
  logic        stall, illegal_addr;
  logic [26:0] busy_vec;

  always #5 clk = ~clk;

  ternary_scoreboard #(.NREGS(27), .LAT_W(3)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_lat(id_lat), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .flush(flush), .stall(stall), .busy_vec(busy_vec), .illegal_addr(illegal_addr)
  );

  typedef struct {
    logic        valid;
    logic [5:0]  rs1;
    logic        u1;
    logic [5:0]  rs2;
    logic        u2;
    logic [5:0]  rd;
    logic        rw;
    logic [2:0]  lat;
    logic        wbv;
    logic [5:0]  wbrd;
    logic        fl;
    logic        rs;
    logic        es;
    logic [26:0] eb;
    logic        ei;
  } vec_t;

  typedef struct {
    int          idx;
    logic        es;
    logic [26:0] eb;
    logic        ei;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   passed = 0;
  int   total  = 0;

  function automatic vec_t mk(logic valid, logic [5:0] rs1, logic u1, logic [5:0] rs2,
                              logic u2, logic [5:0] rd, logic rw, logic [2:0] lat,
                              logic wbv, logic [5:0] wbrd, logic fl, logic rs,
                              logic es, logic [26:0] eb, logic ei);
    vec_t v;
    v.valid = valid; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
    v.rd = rd; v.rw = rw; v.lat = lat; v.wbv = wbv; v.wbrd = wbrd;
    v.fl = fl; v.rs = rs; v.es = es; v.eb = eb; v.ei = ei;
    return v;
  endfunction

  function automatic vec_t idle(logic [26:0] eb, logic ei);
    return mk(0, R0, 0, R0, 0, R0, 0, 0, 0, R0, 0, 0, 0, eb, ei);
  endfunction

  function automatic vec_t iss(logic [5:0] rd, logic [2:0] lat, logic es, logic [26:0] eb);
    return mk(1, R0, 0, R0, 0, rd, 1, lat, 0, R0, 0, 0, es, eb, 0);
  endfunction

  function automatic vec_t rd2(logic [5:0] rs2, logic es, logic [26:0] eb);
    return mk(1, R0, 0, rs2, 1, R0, 0, 0, 0, R0, 0, 0, es, eb, 0);
  endfunction

  function automatic vec_t wb(logic [5:0] rd, logic [26:0] eb, logic ei);
    return mk(0, R0, 0, R0, 0, R0, 0, 0, 1, rd, 0, 0, 0, eb, ei);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  task automatic drive(input vec_t v);
    id_valid = v.valid; id_rs1 = v.rs1; id_uses_rs1 = v.u1; id_rs2 = v.rs2;
    id_uses_rs2 = v.u2; id_rd = v.rd; id_reg_write = v.rw; id_lat = v.lat;
    wb_valid = v.wbv; wb_rd = v.wbrd; flush = v.fl; rst = v.rs;
  endtask

  initial begin
    exp_t e;
    int   bubbles;
    bit   released;

    // Table: each entry is one cycle of inputs plus that cycle's expected outputs.
    vecs.push_back(iss(R14, 1, 0, 0));                                 // 0 ALU L=1
    vecs.push_back(mk(1, R14, 1, R0, 0, R0, 0, 0, 0, R0, 0, 0, 0, B14, 0)); // 1 no bubble
    vecs.push_back(idle(B14, 0));
    vecs.push_back(wb(R14, B14, 0));
    vecs.push_back(idle(0, 0));                                        // 4 commit seen
    vecs.push_back(iss(R5, 2, 0, 0));                                  // 5 load L=2
    vecs.push_back(rd2(R5, 1, B5));                                    // 6 one bubble
    vecs.push_back(rd2(R5, 0, B5));
    vecs.push_back(wb(R5, B5, 0));
    vecs.push_back(idle(0, 0));
    vecs.push_back(iss(R5, 7, 0, 0));                                  // 10 L=7
    for (int k = 0; k < 6; k++) vecs.push_back(rd2(R5, 1, B5));        // 11..16 six bubbles
    vecs.push_back(rd2(R5, 0, B5));
    vecs.push_back(wb(R5, B5, 0));
    vecs.push_back(idle(0, 0));
    vecs.push_back(iss(R20, 4, 0, 0));                                 // 20 WAW L=4
    for (int k = 0; k < 3; k++) vecs.push_back(iss(R20, 1, 1, B20));   // 21..23
    vecs.push_back(iss(R20, 1, 0, B20));
    vecs.push_back(mk(1, R0, 0, R0, 0, R20, 1, 1, 1, R20, 0, 0, 0, B20, 0)); // 25 issue+commit
    vecs.push_back(idle(B20, 0));                                      // issue won
    vecs.push_back(wb(R20, B20, 0));
    vecs.push_back(idle(0, 0));
    vecs.push_back(iss(R0, 7, 0, 0));                                  // 29 R0 not recorded
    vecs.push_back(mk(1, R0, 1, R0, 1, R0, 1, 7, 0, R0, 0, 0, 0, 0, 0));
    vecs.push_back(idle(0, 0));
    vecs.push_back(iss(R5, 7, 0, 0));                                  // 32 two pending
    vecs.push_back(iss(R20, 7, 0, B5));
    vecs.push_back(mk(1, R5, 1, R0, 0, R14, 1, 3, 0, R0, 1, 0, 0, B5 | B20, 0)); // 34 flush
    vecs.push_back(mk(1, R14, 1, R5, 1, R0, 0, 0, 0, R0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, ILL, 1, R0, 0, R0, 0, 0, 0, R0, 0, 0, 0, 0, 0)); // 36 illegal rs1
    vecs.push_back(idle(0, 1));
    vecs.push_back(idle(0, 0));
    vecs.push_back(mk(1, R0, 0, R0, 0, ILL, 1, 3, 0, R0, 0, 0, 0, 0, 0)); // 39 illegal rd
    vecs.push_back(idle(0, 1));
    vecs.push_back(wb(ILL, 0, 0));                                     // 41 illegal wb_rd
    vecs.push_back(idle(0, 1));
    vecs.push_back(mk(1, R0, 0, ILL, 0, R0, 0, 0, 0, R0, 0, 0, 0, 0, 0)); // 43 unused rs2
    vecs.push_back(idle(0, 0));
    vecs.push_back(iss(R5, 7, 0, 0));                                  // 45 reset mid-op
    vecs.push_back(mk(1, ILL, 1, R5, 1, R0, 0, 0, 0, R0, 0, 1, 0, B5, 0));
    vecs.push_back(mk(1, R0, 0, R5, 1, R0, 0, 0, 0, R0, 0, 0, 0, 0, 0));
    vecs.push_back(iss(R22, 0, 0, 0));                                 // 48 lat 0 acts as 1
    vecs.push_back(mk(1, R22, 1, R0, 0, R0, 0, 0, 0, R0, 0, 0, 0, B22, 0));
    vecs.push_back(wb(R22, B22, 0));
    vecs.push_back(idle(0, 0));

    // Reset: outputs are quiet even with a request in ID.
    drive(idle(0, 0));
    rst = 1'b1;
    id_valid = 1'b1; id_uses_rs1 = 1'b1; id_rs1 = R14;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_stall", 32'(stall), 32'd0);
    check("reset_busy_vec", 32'(busy_vec), 32'd0);
    check("reset_illegal", 32'(illegal_addr), 32'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      e.idx = i; e.es = vecs[i].es; e.eb = vecs[i].eb; e.ei = vecs[i].ei;
      exp_q.push_back(e);
      @(negedge clk);
      e = exp_q.pop_front();
      check($sformatf("v%0d_stall", e.idx), 32'(stall), 32'(e.es));
      check($sformatf("v%0d_busy_vec", e.idx), 32'(busy_vec), 32'(e.eb));
      check($sformatf("v%0d_illegal", e.idx), 32'(illegal_addr), 32'(e.ei));
      @(posedge clk);
      #1;
    end

    // L = 3 producer: the dependent in ID should see exactly two bubbles.
    drive(iss(R22, 3, 0, 0));
    @(posedge clk);
    #1;
    drive(mk(1, R22, 1, R0, 0, R0, 0, 0, 0, R0, 0, 0, 0, 0, 0));
    bubbles  = 0;
    released = 1'b0;
    for (int c = 0; c < 20 && !released; c++) begin
      @(negedge clk);
      if (!stall) released = 1'b1;
      else bubbles++;
      @(posedge clk);
      #1;
    end
    check("l3_released", 32'(released), 32'd1);
    check("l3_bubbles", 32'(bubbles), 32'd2);
    drive(wb(R22, 0, 0));
    @(posedge clk);
    #1;
    drive(idle(0, 0));
    @(negedge clk);
    check("l3_commit_busy_vec", 32'(busy_vec), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
